// File: rtl/slave_bfm_pkg.sv
// Shared types for the APB slave BFM: driver FSM states and the captured-transfer record.
// The record's address field is 32 bits wide, matching the default ADDR_WIDTH.
package slave_bfm_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int XFER_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                   write;
    logic [XFER_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0]  data;
    logic                   slverr;
  } xfer_t;

endpackage

// File: rtl/slave_bfm_monitor.sv
// Transfer monitor: registers each completed transfer, pulses valid, counts completions
// and reports protocol violations one cycle after they are seen on the bus.
module slave_bfm_monitor
  import slave_bfm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_done,
  input  logic                  i_proto_err,
  input  xfer_t                 i_xfer,
  output logic                  o_valid,
  output logic                  o_write,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_slverr,
  output logic                  o_proto_err,
  output logic [15:0]           o_count
);

  xfer_t       r_cap;
  logic        r_valid;
  logic        r_proto;
  logic [15:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap   <= '0;
      r_valid <= 1'b0;
      r_proto <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_valid <= i_done;
      r_proto <= i_proto_err;
      if (i_done) begin
        r_cap   <= i_xfer;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_write     = r_cap.write;
  assign o_addr      = ADDR_WIDTH'(r_cap.addr);
  assign o_data      = r_cap.data;
  assign o_slverr    = r_cap.slverr;
  assign o_proto_err = r_proto;
  assign o_count     = r_count;

endmodule

// File: rtl/slave_bfm.sv
// APB slave bus-functional model: register memory with configurable wait states and a monitor.
// Define SLAVE_BFM_PSTRB_EN to add the pstrb byte-strobe input for partial-word writes.
module slave_bfm
  import slave_bfm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
`ifdef SLAVE_BFM_PSTRB_EN
  input  logic [3:0]            pstrb,
`endif
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  mon_valid,
  output logic                  mon_write,
  output logic [ADDR_WIDTH-1:0] mon_addr,
  output logic [DATA_WIDTH-1:0] mon_data,
  output logic                  mon_slverr,
  output logic                  mon_proto_err,
  output logic [15:0]           mon_count
);

  localparam int                    IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

  state_e                r_state;
  state_e                w_next;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_setup;
  logic                  w_in_acc;
  logic                  w_err;
  logic                  w_proto;
  xfer_t                 w_xfer;

  // The state register lags the bus by one cycle, so the first access cycle is seen in SETUP.
  assign w_setup  = psel & ~penable;
  assign w_in_acc = (r_state == SETUP) || (r_state == ACCESS);
  assign w_err    = (paddr[1:0] != 2'b00) || (paddr >= LIMIT);
  assign w_idx    = paddr[2 +: IDX_W];

`ifdef SLAVE_BFM_PSTRB_EN
  assign w_wmask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
`else
  assign w_wmask = '1;
`endif

  always_comb begin
    w_next  = r_state;
    pready  = 1'b0;
    pslverr = 1'b0;
    w_proto = 1'b0;
    if (w_in_acc && psel && penable && (r_cnt == 4'(WAIT_STATES))) begin
      pready  = 1'b1;
      pslverr = w_err;
    end
    if ((w_in_acc && !psel) || ((r_state == IDLE) && penable)) begin
      w_proto = 1'b1;
    end
    if (w_setup) begin
      w_next = SETUP;
    end else begin
      case (r_state)
        SETUP, ACCESS: begin
          if (!psel || pready) w_next = IDLE;
          else if (penable)    w_next = ACCESS;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_setup) begin
        r_cnt <= 4'd0;
      end else if (w_in_acc && psel && penable && !pready) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      r_prdata <= '0;
    end else begin
      if (w_setup) begin
        r_prdata <= (!pwrite && !w_err) ? r_mem[w_idx] : '0;
      end
      if (pready && pwrite && !w_err) begin
        r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (pwdata & w_wmask);
      end
    end
  end

  assign prdata = r_prdata;
  assign w_xfer = '{write:  pwrite,
                    addr:   XFER_ADDR_W'(paddr),
                    data:   pwrite ? pwdata : r_prdata,
                    slverr: w_err};

  slave_bfm_monitor #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_monitor (
    .i_clk      (pclk),
    .i_rst_n    (preset_n),
    .i_done     (pready),
    .i_proto_err(w_proto),
    .i_xfer     (w_xfer),
    .o_valid    (mon_valid),
    .o_write    (mon_write),
    .o_addr     (mon_addr),
    .o_data     (mon_data),
    .o_slverr   (mon_slverr),
    .o_proto_err(mon_proto_err),
    .o_count    (mon_count)
  );

endmodule

// File: tb/tb_slave_bfm.sv
// Directed bench for slave_bfm: instance 0 has no wait states, instance 1 has three.
module tb_slave_bfm;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst_n   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic        mvalid  [2];
  logic        mwrite  [2];
  logic [31:0] maddr   [2];
  logic [31:0] mdata   [2];
  logic        mslverr [2];
  logic        mproto  [2];
  logic [15:0] mcount  [2];
`ifdef SLAVE_BFM_PSTRB_EN
  logic [3:0]  pstrb   [2];
`endif

  slave_bfm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .preset_n(rst_n[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef SLAVE_BFM_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .mon_valid(mvalid[0]), .mon_write(mwrite[0]), .mon_addr(maddr[0]),
    .mon_data(mdata[0]), .mon_slverr(mslverr[0]), .mon_proto_err(mproto[0]),
    .mon_count(mcount[0])
  );

  slave_bfm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(3)) u1 (
    .pclk(pclk), .preset_n(rst_n[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef SLAVE_BFM_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .mon_valid(mvalid[1]), .mon_write(mwrite[1]), .mon_addr(maddr[1]),
    .mon_data(mdata[1]), .mon_slverr(mslverr[1]), .mon_proto_err(mproto[1]),
    .mon_count(mcount[1])
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; returns read data, error flag and number of access cycles.
  // Returns #1 after the completion edge with psel/penable still asserted.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic err, output int acc);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    rd = 32'h0; err = 1'b0; acc = 0;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      acc++;
      if (pready[d]) begin
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
    end
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge pclk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc;
    int          cnt0;
    int          cnt1;

    vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h40, 32'h12345678, 32'h0,        1'b1};
    vt[3]  = '{1'b0, 32'h02, 32'h0,        32'h0,        1'b1};
    vt[4]  = '{1'b0, 32'h3C, 32'h0,        32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[7]  = '{1'b0, 32'h00, 32'h0,        32'h0,        1'b0};
    vt[8]  = '{1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[9]  = '{1'b1, 32'h01, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[10] = '{1'b0, 32'h00, 32'h0,        32'h0,        1'b0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b1;
      paddr[d] = 32'h0; pwdata[d] = 32'hFFFFFFFF;
`ifdef SLAVE_BFM_PSTRB_EN
      pstrb[d] = 4'hF;
`endif
    end
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst prdata", prdata[0], 32'h0);
    chk("rst pready", {31'd0, pready[0]}, 32'h0);
    chk("rst pslverr", {31'd0, pslverr[0]}, 32'h0);
    chk("rst mon_valid", {31'd0, mvalid[0]}, 32'h0);
    chk("rst mon_proto_err", {31'd0, mproto[0]}, 32'h0);
    chk("rst mon_count", {16'd0, mcount[0]}, 32'h0);
    chk("rst mon_data", mdata[0], 32'h0);
    chk("rst pready ws3", {31'd0, pready[1]}, 32'h0);
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    end
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge pclk); #1;

    cnt0 = 0;
    for (int i = 0; i < 11; i++) begin
      xfer(0, vt[i].wr, vt[i].addr, vt[i].wd, rd, err, acc);
      cnt0++;
      chk($sformatf("v%0d access cycles", i), 32'(acc), 32'd1);
      chk($sformatf("v%0d prdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d pslverr", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d mon_valid", i), {31'd0, mvalid[0]}, 32'd1);
      chk($sformatf("v%0d mon_write", i), {31'd0, mwrite[0]}, {31'd0, vt[i].wr});
      chk($sformatf("v%0d mon_addr", i), maddr[0], vt[i].addr);
      chk($sformatf("v%0d mon_data", i), mdata[0], vt[i].wr ? vt[i].wd : vt[i].exp_rd);
      chk($sformatf("v%0d mon_slverr", i), {31'd0, mslverr[0]}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d mon_count", i), {16'd0, mcount[0]}, 32'(cnt0));
      idle(0);
      chk($sformatf("v%0d mon_valid drop", i), {31'd0, mvalid[0]}, 32'd0);
      chk($sformatf("v%0d mon_addr hold", i), maddr[0], vt[i].addr);
    end

    // Back-to-back write then read of the same word, no idle cycle between.
    xfer(0, 1'b1, 32'h08, 32'h0BADF00D, rd, err, acc);
    cnt0++;
    chk("b2b write mon_valid", {31'd0, mvalid[0]}, 32'd1);
    xfer(0, 1'b0, 32'h08, 32'h0, rd, err, acc);
    cnt0++;
    chk("b2b read cycles", 32'(acc), 32'd1);
    chk("b2b read prdata", rd, 32'h0BADF00D);
    chk("b2b mon_count", {16'd0, mcount[0]}, 32'(cnt0));
    idle(0);

    // penable without a setup phase.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h0;
    pwdata[0] = 32'h55555555;
    @(negedge pclk);
    chk("proto pready", {31'd0, pready[0]}, 32'd0);
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("proto mon_proto_err", {31'd0, mproto[0]}, 32'd1);
    chk("proto mon_valid", {31'd0, mvalid[0]}, 32'd0);
    @(posedge pclk); #1;
    chk("proto pulse drop", {31'd0, mproto[0]}, 32'd0);
    chk("proto mon_count", {16'd0, mcount[0]}, 32'(cnt0));
    xfer(0, 1'b0, 32'h00, 32'h0, rd, err, acc);
    cnt0++;
    chk("proto mem unchanged", rd, 32'h0);
    idle(0);

    // Reset during the access phase of a write to 0x08.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h08;
    pwdata[0] = 32'h12345678;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    @(negedge pclk);
    rst_n[0] = 1'b0;
    #1;
    chk("midrst pready", {31'd0, pready[0]}, 32'd0);
    chk("midrst mon_count", {16'd0, mcount[0]}, 32'd0);
    @(posedge pclk); #1;
    chk("midrst mon_valid", {31'd0, mvalid[0]}, 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    rst_n[0] = 1'b1;
    @(posedge pclk); #1;
    chk("midrst mon_valid after", {31'd0, mvalid[0]}, 32'd0);
    cnt0 = 0;
    xfer(0, 1'b0, 32'h08, 32'h0, rd, err, acc);
    cnt0++;
    chk("midrst read 0x08", rd, 32'h0);
    idle(0);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, err, acc);
    cnt0++;
    chk("midrst read 0x04", rd, 32'h0);
    chk("midrst mon_count", {16'd0, mcount[0]}, 32'(cnt0));
    idle(0);

`ifdef SLAVE_BFM_PSTRB_EN
    xfer(0, 1'b1, 32'h14, 32'h11223344, rd, err, acc);
    idle(0);
    pstrb[0] = 4'b0011;
    xfer(0, 1'b1, 32'h14, 32'hAABBCCDD, rd, err, acc);
    idle(0);
    pstrb[0] = 4'hF;
    xfer(0, 1'b0, 32'h14, 32'h0, rd, err, acc);
    chk("pstrb merged read", rd, 32'h1122CCDD);
    idle(0);
`endif

    // Three wait states.
    cnt1 = 0;
    xfer(1, 1'b0, 32'h00, 32'h0, rd, err, acc);
    cnt1++;
    chk("ws3 read cycles", 32'(acc), 32'd4);
    chk("ws3 read prdata", rd, 32'h0);
    chk("ws3 mon_valid", {31'd0, mvalid[1]}, 32'd1);
    chk("ws3 mon_count", {16'd0, mcount[1]}, 32'(cnt1));
    idle(1);
    chk("ws3 mon_valid once", {31'd0, mvalid[1]}, 32'd0);
    xfer(1, 1'b1, 32'h0C, 32'h13579BDF, rd, err, acc);
    cnt1++;
    chk("ws3 write cycles", 32'(acc), 32'd4);
    idle(1);
    xfer(1, 1'b0, 32'h0C, 32'h0, rd, err, acc);
    cnt1++;
    chk("ws3 readback", rd, 32'h13579BDF);
    idle(1);

    // psel dropped during wait states aborts the write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10;
    pwdata[1] = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(negedge pclk);
    chk("abort pready", {31'd0, pready[1]}, 32'd0);
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    chk("abort mon_proto_err", {31'd0, mproto[1]}, 32'd1);
    chk("abort mon_valid", {31'd0, mvalid[1]}, 32'd0);
    chk("abort mon_count", {16'd0, mcount[1]}, 32'(cnt1));
    xfer(1, 1'b0, 32'h10, 32'h0, rd, err, acc);
    cnt1++;
    chk("abort mem unchanged", rd, 32'h0);
    chk("abort read mon_count", {16'd0, mcount[1]}, 32'(cnt1));
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/slave_bfm.md
SLAVE_BFM -- requirements
Module: slave_bfm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; fixed at 32.
- MEM_DEPTH, 16, number of 32-bit register words; power of two.
- WAIT_STATES, 0, wait cycles inserted in every access phase; range 0..15.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pclk, in, 1, the single clock.
- preset_n, in, 1, reset; asynchronous, active-low.
- psel, in, 1, slave select.
- penable, in, 1, access phase.
- pwrite, in, 1, 1 = write.
- paddr, in, ADDR_WIDTH, byte address.
- pwdata, in, 32, write data.
- prdata, out, 32, read data.
- pready, out, 1, transfer completes this cycle.
- pslverr, out, 1, error response.
- mon_valid, out, 1, one-cycle pulse per completed transfer.
- mon_write, out, 1, direction of the captured transfer.
- mon_addr, out, ADDR_WIDTH, captured address.
- mon_data, out, 32, captured pwdata for a write, or prdata for a read.
- mon_slverr, out, 1, captured error flag.
- mon_proto_err, out, 1, one-cycle pulse on a protocol violation.
- mon_count, out, 16, count of completed transfers; wraps from 0xFFFF to 0.

Function
REQ-003 The driver FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-004 Transitions:
- Any state goes to SETUP when psel=1 and penable=0.
- SETUP goes to ACCESS when penable=1.
- ACCESS goes to IDLE on completion when psel=0.
- ACCESS goes to SETUP on completion when psel=1 and penable=0 (back-to-back transfers).
REQ-005 On entry to SETUP, the wait counter SHALL clear to 0.
REQ-006 In ACCESS, the wait counter SHALL increment each cycle while pready=0.
REQ-007 pready SHALL be combinational: 1 when state=ACCESS, psel=1, penable=1 and counter==WAIT_STATES, else 0.
REQ-008 Latency: with WAIT_STATES=0 a transfer SHALL complete in 2 cycles (setup + access); each wait state adds 1 cycle.
REQ-009 A transfer completes at the rising pclk edge where psel, penable and pready are all 1.
REQ-010 An address SHALL be in error when it is misaligned (paddr[1:0]!=0) or when paddr >= MEM_DEPTH*4.
REQ-011 For a valid address, the word index SHALL be paddr[2 +: log2(MEM_DEPTH)].
REQ-012 A completed write to a valid address SHALL update the indexed word; a write to an error address SHALL leave memory unchanged.
REQ-013 prdata SHALL be registered from the indexed word on the SETUP cycle and held through ACCESS; it SHALL be 0 for an error address or a write.
REQ-014 pslverr SHALL equal the error condition while pready=1, and 0 otherwise.
REQ-015 A read from an error address SHALL complete with prdata=0 and pslverr=1.
REQ-016 penable=1 while state=IDLE SHALL be ignored: no transfer, no memory change, and mon_proto_err pulses for 1 cycle.
REQ-017 psel falling in ACCESS before pready SHALL abort the transfer: go to IDLE, no memory change, mon_proto_err pulses.
REQ-018 The cycle after each completion SHALL:
- pulse mon_valid for 1 cycle;
- register mon_write, mon_addr, mon_data and mon_slverr, and hold them until the next completion;
- increment mon_count by 1.
REQ-019 A write followed immediately by a read of the same word SHALL return the newly written data.

Reset
REQ-020 While preset_n=0, asynchronously:
- state = IDLE and wait counter = 0;
- every memory word = 0x0000_0000;
- prdata, pready, pslverr and every mon_* output = 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no memory update and no mon_valid pulse.
REQ-022 After reset deassertion, the first psel=1, penable=0 cycle SHALL start a normal transfer.

Configuration
REQ-023 Macro SLAVE_BFM_PSTRB_EN, when defined, SHALL add input pstrb (4 bits); a completed write SHALL then update only the bytes whose strobe bit is 1.
REQ-024 With SLAVE_BFM_PSTRB_EN undefined, pstrb SHALL be absent and every write SHALL update the full word.

Structure
REQ-025 Package slave_bfm_pkg SHALL hold:
- the FSM state enum (IDLE/SETUP/ACCESS);
- the captured-transfer struct (write, addr, data, slverr);
- constant DATA_WIDTH=32.
REQ-026 The monitor capture logic (REQ-016 to REQ-018) SHALL be sub-module slave_bfm_monitor, instantiated once inside slave_bfm.

Verification
REQ-027 The bench SHALL cover these scenarios with WAIT_STATES=0 unless stated:
- Write 0xDEADBEEF to 0x04, then read 0x04 -> 2-cycle transfers; prdata=0xDEADBEEF, pslverr=0; mon_count=2.
- WAIT_STATES=3, read 0x00 after reset -> pready high on the 4th access cycle; prdata=0; mon_valid pulses once.
- Write to 0x40 (out of range) and read 0x02 (misaligned) -> pslverr=1 with pready; memory unchanged; mon_slverr=1.
- penable=1 without a setup phase -> mon_proto_err pulses; mon_count unchanged.
- preset_n low during ACCESS of a write to 0x08 -> a later read of 0x08 returns 0; no mon_valid pulse.
- With SLAVE_BFM_PSTRB_EN: pstrb=4'b0011, write 0xAABBCCDD over 0x11223344 -> read returns 0x1122CCDD.
